timing_ring_clock_control: RTL and testbench
============================================

// Module: timing_ring_clock_control
// PURPOSE
//  Consumes the free-running 1 MHz oscillator level from the TAF oscillator card (pin D).
//  Produces the 1620 machine-cycle clock ring: RING_LEN one-hot positions (A..J).
//  - Each position lasts DIV oscillator periods, so a 20 us memory cycle at defaults.
//  - Start/stop control always completes whole cycles.
//  - A watchdog faults the ring if the oscillator dies.
// PARAMETERS
//  RING_LEN     10    number of ring positions; bit0 = A, bit RING_LEN-1 = J
//  DIV          2     oscillator rising edges per ring step (>=1)
//  OSC_TIMEOUT  1000  clk cycles without an osc rising edge before osc_fault sets
// PORTS
//  clk          in   1         sampling clock; must be >=10x osc frequency (sim: 100 MHz)
//  reset_n      in   1         synchronous, active-low reset
//  osc          in   1         raw oscillator level from TAF pin D; asynchronous to clk
//  start        in   1         request to start cycling; sampled every clk
//  stop         in   1         request to stop at the end of the current cycle; sampled every clk
//  ring         out  RING_LEN  one-hot clock ring position
//  cycle_end    out  1         one-clk pulse on the J->A wrap
//  running      out  1         high while in RUN
//  osc_fault    out  1         sticky; oscillator lost
// BEHAVIOUR
//  Synchronisation and edge detection
//  - osc passes through a 2-flop synchroniser (s1, s2), then an edge register s3.
//  - osc_rise = s2 & ~s3.
//  - An osc rise is acted on at the 3rd clk edge after osc goes high.
//  Prescaler
//  - Counts osc_rise from 0 to DIV-1. On wrap it asserts tick for one clk.
//  - Held at 0 outside RUN, and cleared on entry to RUN.
//  States
//  - IDLE: ring = A, running = 0.
//    - start=1 and osc_fault=0 -> RUN on the next edge; running rises on that edge.
//    - stop is ignored in IDLE, except when simultaneous with start (see boundaries).
//  - RUN: each tick rotates ring one position left (A->B ... J->A).
//    - On the J->A edge, cycle_end=1 for exactly that one clk.
//    - stop=1 sets stop_pending; further stop pulses have no added effect.
//    - J->A wrap with stop_pending=1 -> IDLE on the same edge: ring=A, running=0, stop_pending cleared, cycle_end still pulses.
//    - start in RUN is ignored.
//  - First A->B step occurs DIV osc rises after RUN entry, so position A gets a full 2 us.
//  Watchdog
//  - Counter clears on osc_rise; otherwise increments, saturating.
//  - Reaching OSC_TIMEOUT sets osc_fault, which forces IDLE and ring=A immediately. No cycle_end is produced.
//  - start is ignored while osc_fault=1. Only reset clears osc_fault.
//  Reset (synchronous, active-low)
//  - ring=A, cycle_end=0, running=0, osc_fault=0.
//  - Prescaler, watchdog, stop_pending and sync flops = 0.
//  - Reset mid-cycle abandons the cycle with no cycle_end.
//  Boundaries
//  - start & stop in the same clk in IDLE: enter RUN with stop_pending=1, i.e. exactly one cycle.
//  - stop in the same clk as the J->A tick: counts for this wrap, so IDLE follows.
//  - ring is always exactly one-hot. All widths derive from $clog2 of the parameters.
// CONFIGURATION
//  SINGLE_CYCLE_EN (macro)
//  - Defined: adds input port single_cycle (1 bit). If single_cycle=1 when start is
//    accepted in IDLE, stop_pending is set on RUN entry, so one ring cycle runs, then IDLE.
//    This is the manual single-cycle key.
//  - Undefined: the port is absent; behaviour is identical to single_cycle=0.
// TESTING  (clk 10 ns; osc per TAF: 200 ns low / 800 ns high, 1 us period)
//  1 Reset: reset_n=0 for 3 clk -> ring=10'b0000000001, running=0, cycle_end=0, osc_fault=0.
//  2 Run: 1-clk start pulse -> running=1; ring steps every 2000 ns A..J; cycle_end pulses every 20 us; continues for 3 cycles.
//  3 Stop: stop pulse while ring=D -> steps through J, wraps to A; running=0 on the wrap; exactly one more cycle_end; then static.
//  4 Simultaneous: start=stop=1 for 1 clk in IDLE -> exactly 10 steps and 1 cycle_end, then IDLE at A.
//  5 Fault: in RUN, hold osc=0 -> after 1000 clk osc_fault=1, ring=A, running=0; start ignored; reset clears the fault.
//  6 SINGLE_CYCLE_EN: single_cycle=1 plus start pulse -> one full cycle, one cycle_end, IDLE.
//    Also: reset_n=0 while ring=F -> ring=A with no cycle_end.

Source files
------------

// File: rtl/timing_ring_clock_control.sv
// One-hot machine-cycle clock ring stepped by a prescaled, synchronised oscillator,
// with whole-cycle start/stop and an oscillator-loss watchdog. Optional macro: SINGLE_CYCLE_EN.
module timing_ring_clock_control #(
    parameter int RING_LEN    = 10,
    parameter int DIV         = 2,
    parameter int OSC_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                osc,
    input  logic                start,
    input  logic                stop,
`ifdef SINGLE_CYCLE_EN
    input  logic                single_cycle,
`endif
    output logic [RING_LEN-1:0] ring,
    output logic                cycle_end,
    output logic                running,
    output logic                osc_fault
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WW = $clog2(OSC_TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [RING_LEN-1:0] RING_A = {{(RING_LEN-1){1'b0}}, 1'b1};

    logic          sync1_r, sync2_r, sync3_r;
    logic [0:0]    state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [WW-1:0] wdog_r, wdog_s;
    logic          stop_pend_r, stop_pend_s;
    logic [RING_LEN-1:0] ring_s;
    logic          cycle_end_s, running_s, fault_s;
    logic          osc_rise_s, tick_s, wrap_s, single_s;

    // Next-state logic: watchdog, prescaler, ring rotation and start/stop control.
    always_comb begin
`ifdef SINGLE_CYCLE_EN
        single_s = single_cycle;
`else
        single_s = 1'b0;
`endif
        osc_rise_s  = sync2_r & ~sync3_r;
        tick_s      = osc_rise_s & (presc_r == PW'(DIV - 1));
        wrap_s      = tick_s & ring_r_top();
        state_s     = state_r;
        ring_s      = ring;
        presc_s     = presc_r;
        stop_pend_s = stop_pend_r;
        cycle_end_s = 1'b0;

        if (osc_rise_s) begin
            wdog_s = {WW{1'b0}};
        end else if (wdog_r == WW'(OSC_TIMEOUT)) begin
            wdog_s = wdog_r;
        end else begin
            wdog_s = wdog_r + WW'(1);
        end
        fault_s = osc_fault | (wdog_s == WW'(OSC_TIMEOUT));

        // A lost oscillator overrides everything, including a wrap on the same edge.
        if (fault_s) begin
            state_s     = ST_IDLE;
            ring_s      = RING_A;
            presc_s     = {PW{1'b0}};
            stop_pend_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_s = {PW{1'b0}};
                    ring_s  = RING_A;
                    if (start) begin
                        state_s     = ST_RUN;
                        stop_pend_s = stop | single_s;
                    end else begin
                        stop_pend_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    stop_pend_s = stop_pend_r | stop;
                    if (tick_s) begin
                        presc_s = {PW{1'b0}};
                        ring_s  = {ring[RING_LEN-2:0], ring[RING_LEN-1]};
                    end else if (osc_rise_s) begin
                        presc_s = presc_r + PW'(1);
                    end else begin
                        presc_s = presc_r;
                    end
                    if (wrap_s) begin
                        cycle_end_s = 1'b1;
                        if (stop_pend_s) begin
                            state_s     = ST_IDLE;
                            stop_pend_s = 1'b0;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        cycle_end_s = 1'b0;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    ring_s      = RING_A;
                    presc_s     = {PW{1'b0}};
                    stop_pend_s = 1'b0;
                end
            endcase
        end
        running_s = (state_s == ST_RUN);
    end

    function automatic logic ring_r_top();
        return ring[RING_LEN-1];
    endfunction

    // State registers and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            sync3_r     <= 1'b0;
            state_r     <= ST_IDLE;
            presc_r     <= {PW{1'b0}};
            wdog_r      <= {WW{1'b0}};
            stop_pend_r <= 1'b0;
            ring        <= RING_A;
            cycle_end   <= 1'b0;
            running     <= 1'b0;
            osc_fault   <= 1'b0;
        end else begin
            sync1_r     <= osc;
            sync2_r     <= sync1_r;
            sync3_r     <= sync2_r;
            state_r     <= state_s;
            presc_r     <= presc_s;
            wdog_r      <= wdog_s;
            stop_pend_r <= stop_pend_s;
            ring        <= ring_s;
            cycle_end   <= cycle_end_s;
            running     <= running_s;
            osc_fault   <= fault_s;
        end
    end

endmodule

// File: tb/tb_timing_ring_clock_control.sv
// Randomised bench for timing_ring_clock_control against a count-based reference model.
module tb_timing_ring_clock_control;

    localparam int RING_LEN    = 10;
    localparam int DIV         = 2;
    localparam int OSC_TIMEOUT = 1000;

    logic clk, reset_n, osc, start, stop, single_cycle, osc_en;
    logic [RING_LEN-1:0] ring;
    logic cycle_end, running, osc_fault;

    int checks = 0;
    int errors = 0;

    timing_ring_clock_control #(
        .RING_LEN(RING_LEN), .DIV(DIV), .OSC_TIMEOUT(OSC_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .osc(osc), .start(start), .stop(stop),
`ifdef SINGLE_CYCLE_EN
        .single_cycle(single_cycle),
`endif
        .ring(ring), .cycle_end(cycle_end), .running(running), .osc_fault(osc_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator: ~200 low / ~800 high with jitter; toggles on even times, clk edges are odd.
    initial begin
        osc = 1'b0;
        #2;
        forever begin
            if (osc_en) begin
                osc = 1'b0;
                #(2 * $urandom_range(95, 105));
                osc = 1'b1;
                #(2 * $urandom_range(395, 405));
            end else begin
                osc = 1'b0;
                #10;
            end
        end
    end

    // Reference model: counts oscillator rises since RUN entry; position = steps mod RING_LEN.
    bit [2:0] m_hist;
    int  m_silent, m_rises, m_pos;
    bit  m_run, m_fault, m_sp, m_ce;

    always @(posedge clk) begin : model
        bit rise, sp;
        int sil, r, p;
        if (!reset_n) begin
            m_hist <= 3'b000; m_silent <= 0; m_rises <= 0; m_pos <= 0;
            m_run <= 1'b0; m_fault <= 1'b0; m_sp <= 1'b0; m_ce <= 1'b0;
        end else begin
            rise = m_hist[1] & ~m_hist[2];
            m_hist <= {m_hist[1:0], osc};
            sil = rise ? 0 : ((m_silent < OSC_TIMEOUT) ? m_silent + 1 : m_silent);
            m_silent <= sil;
            m_ce <= 1'b0;
            if (m_fault || sil == OSC_TIMEOUT) begin
                m_fault <= 1'b1; m_run <= 1'b0; m_pos <= 0; m_sp <= 1'b0; m_rises <= 0;
            end else if (!m_run) begin
                m_pos <= 0; m_rises <= 0;
                if (start) begin
                    m_run <= 1'b1;
                    m_sp  <= stop | single_cycle;
                end
            end else begin
                sp = m_sp | stop;
                r  = m_rises + (rise ? 1 : 0);
                p  = m_pos;
                if (rise && (r % DIV) == 0) begin
                    p = (m_pos + 1) % RING_LEN;
                    if (p == 0) begin
                        m_ce <= 1'b1;
                        if (sp) begin
                            m_run <= 1'b0;
                            sp = 1'b0;
                        end
                    end
                end
                m_rises <= r; m_pos <= p; m_sp <= sp;
            end
        end
    end

    wire [RING_LEN+2:0] dut_vec = {ring, running, cycle_end, osc_fault};

    function automatic logic [RING_LEN+2:0] exp_vec();
        logic [RING_LEN-1:0] r;
        r = {RING_LEN{1'b0}};
        r[m_pos] = 1'b1;
        return {r, m_run, m_ce, m_fault};
    endfunction

    task automatic pulse_start(input logic with_stop, input logic with_single);
        @(negedge clk);
        start = 1'b1; stop = with_stop; single_cycle = with_single;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; single_cycle = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ring !== 10'b0000000001 || running !== 1'b0 || cycle_end !== 1'b0 || osc_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ring=%b run=%b ce=%b flt=%b want ring=0000000001 0 0 0",
                     ring, running, cycle_end, osc_fault);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_run();
        int ce_n, last_ce, now;
        ce_n = 0; last_ce = 0; now = 0;
        pulse_start(1'b0, 1'b0);
        repeat (6300) begin
            @(negedge clk);
            now++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL run_lockstep t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
            if (cycle_end) begin
                if (ce_n > 0) begin
                    checks++;
                    if (now - last_ce < 1955 || now - last_ce > 2045) begin
                        errors++;
                        $display("FAIL run_period got %0d clk want 1955..2045", now - last_ce);
                    end
                end
                ce_n++;
                last_ce = now;
            end
        end
        checks++;
        if (ce_n != 3 || running !== 1'b1) begin
            errors++;
            $display("FAIL run_cycles got ce=%0d run=%b want ce=3 run=1", ce_n, running);
        end
    endtask

    task automatic test_stop();
        int n, ce_n;
        bit done;
        n = 0;
        while (ring !== 10'b0000001000 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2500) begin
            errors++;
            $display("FAIL stop_wait_d got ring=%b want 0000001000 within 2500 clk", ring);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        ce_n = 0; done = 1'b0;
        for (int i = 0; i < 2600 && !done; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL stop_lockstep t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
            if (cycle_end) ce_n++;
            if (!running) begin
                done = 1'b1;
                checks++;
                if (cycle_end !== 1'b1 || ring !== 10'b0000000001) begin
                    errors++;
                    $display("FAIL stop_wrap got ce=%b ring=%b want ce=1 ring=0000000001", cycle_end, ring);
                end
            end
        end
        repeat (500) begin
            @(negedge clk);
            if (cycle_end) ce_n++;
        end
        checks++;
        if (!done || ce_n != 1 || ring !== 10'b0000000001 || running !== 1'b0) begin
            errors++;
            $display("FAIL stop_final got done=%0d ce=%0d ring=%b run=%b want 1 1 0000000001 0",
                     done, ce_n, ring, running);
        end
    endtask

    task automatic test_simultaneous();
        int steps, ce_n;
        logic [RING_LEN-1:0] prev;
        steps = 0; ce_n = 0;
        prev = ring;
        pulse_start(1'b1, 1'b0);
        repeat (3000) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL simul_lockstep t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
            if (ring !== prev) steps++;
            if (cycle_end) ce_n++;
            prev = ring;
        end
        checks++;
        if (steps != 10 || ce_n != 1 || running !== 1'b0 || ring !== 10'b0000000001) begin
            errors++;
            $display("FAIL simul_count got steps=%0d ce=%0d run=%b ring=%b want 10 1 0 0000000001",
                     steps, ce_n, running, ring);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int n;
        pulse_start(1'b0, 1'b0);
        n = 0;
        while (ring !== 10'b0000100000 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (n >= 2500 || ring !== 10'b0000000001 || cycle_end !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got wait=%0d ring=%b ce=%b run=%b want ring=0000000001 0 0",
                     n, ring, cycle_end, running);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef SINGLE_CYCLE_EN
    task automatic test_single_cycle();
        int ce_n;
        ce_n = 0;
        pulse_start(1'b0, 1'b1);
        repeat (3000) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL single_lockstep t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
            if (cycle_end) ce_n++;
        end
        checks++;
        if (ce_n != 1 || running !== 1'b0 || ring !== 10'b0000000001) begin
            errors++;
            $display("FAIL single_count got ce=%0d run=%b ring=%b want 1 0 0000000001", ce_n, running, ring);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_lockstep t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
            start   = ($urandom_range(0, 399) == 0);
            stop    = ($urandom_range(0, 1499) == 0);
            reset_n = !($urandom_range(0, 4999) == 0);
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_fault();
        int n;
        pulse_start(1'b0, 1'b0);
        repeat (300) @(negedge clk);
        osc_en = 1'b0;
        n = 0;
        while (!osc_fault && n < 2500) begin
            @(negedge clk);
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fault_lockstep t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
        end
        checks++;
        if (osc_fault !== 1'b1 || ring !== 10'b0000000001 || running !== 1'b0 || cycle_end !== 1'b0) begin
            errors++;
            $display("FAIL fault_set got flt=%b ring=%b run=%b ce=%b want 1 0000000001 0 0",
                     osc_fault, ring, running, cycle_end);
        end
        pulse_start(1'b0, 1'b0);
        osc_en = 1'b1;
        repeat (400) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fault_hold t=%0t got %b want %b", $time, dut_vec, exp_vec());
            end
        end
        pulse_start(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (osc_fault !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky got flt=%b run=%b want 1 0", osc_fault, running);
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (osc_fault !== 1'b0 || ring !== 10'b0000000001) begin
            errors++;
            $display("FAIL fault_clear got flt=%b ring=%b want 0 0000000001", osc_fault, ring);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; single_cycle = 1'b0; osc_en = 1'b1;
        test_reset();
        test_run();
        test_stop();
        test_simultaneous();
        test_reset_mid_cycle();
`ifdef SINGLE_CYCLE_EN
        test_single_cycle();
`endif
        test_random();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
